// File: rtl/egm_reaction_timer_mc.sv
// Multi-channel EGM reaction timer.
// Each channel waits a programmed delay, drives its stimulus, then counts prescaled ticks
// until the synchronised response rises or a timeout expires. Results are arbitrated
// (lowest channel first) into a first-word-fall-through FIFO read through a valid/ready port.
// Optional macro EGM_DEBOUNCE_EN inserts a 16-tick debouncer after each response synchroniser.

module egm_reaction_timer_mc #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned PRESCALE      = 50,
  parameter int unsigned TIMEOUT_TICKS = 65535,
  parameter int unsigned FIFO_DEPTH    = 8,
  localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clkin_50,
  input  logic              rst,
  input  logic              start,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [CNT_W-1:0]  delay_ticks,
  input  logic              abort,
  input  logic [NUM_CH-1:0] response_in,
  output logic [NUM_CH-1:0] stimulus_out,
  output logic [NUM_CH-1:0] egm_leds,
  output logic [NUM_CH-1:0] busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CH_W-1:0]   res_ch,
  output logic [1:0]        res_status,
  output logic [CNT_W-1:0]  res_count
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = CH_W + 2 + CNT_W;

  localparam logic [1:0]       StatOk      = 2'b00;
  localparam logic [1:0]       StatEarly   = 2'b01;
  localparam logic [1:0]       StatTimeout = 2'b10;
  localparam logic [CNT_W-1:0] TimeoutVal  = CNT_W'(TIMEOUT_TICKS);
  localparam logic [PW-1:0]    PresLast    = PW'(PRESCALE - 1);
  localparam logic [AW:0]      FifoFull    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StDelay, StStim, StDone} ch_state_e;

  // ---------------------------------------------------------------------------
  // Shared tick generator (only rst clears it; abort leaves the phase alone)
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  // Count 0..PRESCALE-1 and pulse tick at the wrap.
  always_comb begin
    tick    = (presc_q == PresLast);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge clkin_50) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  // ---------------------------------------------------------------------------
  // Response synchronisers and rising-edge detection
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] sync1_q, sync1_d;
  logic [NUM_CH-1:0] sync2_q, sync2_d;
  logic [NUM_CH-1:0] resp_prev_q, resp_prev_d;
  logic [NUM_CH-1:0] edge_q, edge_d;
  logic [NUM_CH-1:0] resp_clean;

`ifdef EGM_DEBOUNCE_EN
  logic [NUM_CH-1:0] db_q, db_d;
  logic [3:0]        db_cnt_q [NUM_CH];
  logic [3:0]        db_cnt_d [NUM_CH];

  // Follow the synchronised input only after it has differed for 16 consecutive ticks.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NUM_CH; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (tick) begin
        if (db_cnt_q[i] == 4'd15) begin
          db_d[i]     = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 4'd1;
        end
      end
    end
    resp_clean = db_q;
  end

  // Debouncer registers.
  always_ff @(posedge clkin_50) begin
    if (rst) begin
      db_q <= '0;
      for (int i = 0; i < NUM_CH; i++) db_cnt_q[i] <= '0;
    end else begin
      db_q <= db_d;
      for (int i = 0; i < NUM_CH; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end
`else
  // Edges come straight from the two-flop synchroniser.
  always_comb begin
    resp_clean = sync2_q;
  end
`endif

  // Two-flop synchroniser feed and registered rising-edge detect.
  always_comb begin
    sync1_d     = response_in;
    sync2_d     = sync1_q;
    resp_prev_d = resp_clean;
    edge_d      = resp_clean & ~resp_prev_q;
  end

  // Synchroniser and edge registers.
  always_ff @(posedge clkin_50) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      resp_prev_q <= '0;
      edge_q      <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      resp_prev_q <= resp_prev_d;
      edge_q      <= edge_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel measurement FSMs
  // ---------------------------------------------------------------------------
  ch_state_e         st_q      [NUM_CH];
  ch_state_e         st_d      [NUM_CH];
  logic [CNT_W-1:0]  cnt_q     [NUM_CH];
  logic [CNT_W-1:0]  cnt_d     [NUM_CH];
  logic [CNT_W-1:0]  cap_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cap_cnt_d [NUM_CH];
  logic [1:0]        cap_st_q  [NUM_CH];
  logic [1:0]        cap_st_d  [NUM_CH];
  logic [NUM_CH-1:0] stim_q, stim_d;
  logic [NUM_CH-1:0] grant;

  // Next-state logic for every channel; abort overrides everything.
  always_comb begin
    stim_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i]      = st_q[i];
      cnt_d[i]     = cnt_q[i];
      cap_cnt_d[i] = cap_cnt_q[i];
      cap_st_d[i]  = cap_st_q[i];
      unique case (st_q[i])
        StIdle: begin
          // ch_sel values outside 0..NUM_CH-1 never match a channel index.
          if (start && (int'(ch_sel) == i)) begin
            cnt_d[i] = delay_ticks;
            st_d[i]  = StDelay;
          end
        end
        StDelay: begin
          if (edge_q[i]) begin
            cap_st_d[i]  = StatEarly;
            cap_cnt_d[i] = '0;
            st_d[i]      = StDone;
          end else if (cnt_q[i] == '0) begin
            cnt_d[i] = '0;
            st_d[i]  = StStim;
          end else if (tick) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        StStim: begin
          // A response edge beats a coincident timeout.
          if (edge_q[i]) begin
            cap_st_d[i]  = StatOk;
            cap_cnt_d[i] = cnt_q[i];
            st_d[i]      = StDone;
          end else if (cnt_q[i] >= TimeoutVal) begin
            cap_st_d[i]  = StatTimeout;
            cap_cnt_d[i] = TimeoutVal;
            st_d[i]      = StDone;
          end else if (tick) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        StDone: begin
          if (grant[i]) st_d[i] = StIdle;
        end
        default: st_d[i] = StIdle;
      endcase
      if (abort) st_d[i] = StIdle;
      stim_d[i] = (st_d[i] == StStim);
    end
  end

  // Channel state registers; stimulus is registered so the pins never glitch.
  always_ff @(posedge clkin_50) begin
    if (rst) begin
      stim_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]      <= StIdle;
        cnt_q[i]     <= '0;
        cap_cnt_q[i] <= '0;
        cap_st_q[i]  <= StatOk;
      end
    end else begin
      stim_q <= stim_d;
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]      <= st_d[i];
        cnt_q[i]     <= cnt_d[i];
        cap_cnt_q[i] <= cap_cnt_d[i];
        cap_st_q[i]  <= cap_st_d[i];
      end
    end
  end

  // Channel status outputs.
  always_comb begin
    stimulus_out = stim_q;
    egm_leds     = stim_q;
    for (int i = 0; i < NUM_CH; i++) busy[i] = (st_q[i] != StIdle);
  end

  // ---------------------------------------------------------------------------
  // Fixed-priority arbiter and result FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [EW-1:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full, pop, push;
  logic [EW-1:0]    push_entry;
  logic [EW-1:0]    head;

  // Grant the lowest-index DONE channel when a slot is free or freed this cycle.
  // Pushes are suppressed under abort so pending DONE results are discarded.
  always_comb begin
    full       = (count_q == FifoFull);
    res_valid  = (count_q != '0);
    pop        = res_valid & res_ready;
    grant      = '0;
    push       = 1'b0;
    push_entry = '0;
    if (!abort && (!full || pop)) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!push && (st_q[i] == StDone)) begin
          grant[i]   = 1'b1;
          push       = 1'b1;
          push_entry = {CH_W'(i), cap_st_q[i], cap_cnt_q[i]};
        end
      end
    end
  end

  // FIFO pointer, occupancy and storage next-state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers.
  always_ff @(posedge clkin_50) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until written, outputs are masked when empty.
  always_ff @(posedge clkin_50) begin
    mem_q <= mem_d;
  end

  // First-word-fall-through head, forced to zero while the FIFO is empty.
  always_comb begin
    head       = res_valid ? mem_q[rd_ptr_q] : '0;
    res_ch     = head[EW-1 -: CH_W];
    res_status = head[CNT_W+1 -: 2];
    res_count  = head[CNT_W-1:0];
  end

endmodule

// File: tb/tb_egm_reaction_timer_mc.sv
// Self-checking bench for egm_reaction_timer_mc (PRESCALE=4, TIMEOUT_TICKS=20, FIFO_DEPTH=2).

module tb_egm_reaction_timer_mc;

  localparam int MResp  = 0;
  localparam int MEarly = 1;
  localparam int MNone  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  ch_sel;
  logic [15:0] delay_ticks;
  logic        abort;
  logic [3:0]  response_in;
  logic [3:0]  stimulus_out;
  logic [3:0]  egm_leds;
  logic [3:0]  busy;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_ch;
  logic [1:0]  res_status;
  logic [15:0] res_count;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int ch;
    int delay;
    int mode;
    int n;
    int exp_st;
    int cnt_lo;
    int cnt_hi;
    int lat_lo;
    int lat_hi;
  } vec_t;

  vec_t vecs [5];

  egm_reaction_timer_mc #(
    .NUM_CH       (4),
    .CNT_W        (16),
    .PRESCALE     (4),
    .TIMEOUT_TICKS(20),
    .FIFO_DEPTH   (2)
  ) dut (
    .clkin_50    (clk),
    .rst         (rst),
    .start       (start),
    .ch_sel      (ch_sel),
    .delay_ticks (delay_ticks),
    .abort       (abort),
    .response_in (response_in),
    .stimulus_out(stimulus_out),
    .egm_leds    (egm_leds),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_ch      (res_ch),
    .res_status  (res_status),
    .res_count   (res_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_assert++;
    if (got < lo || got > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic start_ch(input int ch, input int dly);
    @(negedge clk);
    ch_sel      = 2'(ch);
    delay_ticks = 16'(dly);
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic wait_stim(input logic [3:0] mask, input string name);
    int k = 0;
    while (((stimulus_out & mask) != mask) && k < 60) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'((stimulus_out & mask) == mask), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!res_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(res_valid), 32'd1);
  endtask

  // One single-channel measurement with the consumer always ready.
  task automatic run_one(input vec_t v, input string tag);
    int k       = 0;
    int rise_k  = -1;
    int stim_n  = 0;
    bit got     = 1'b0;
    int g_ch    = 0;
    int g_st    = 0;
    int g_cnt   = 0;
    res_ready   = 1'b1;
    @(negedge clk);
    ch_sel      = 2'(v.ch);
    delay_ticks = 16'(v.delay);
    start       = 1'b1;
    while (!got && k < 400) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (stimulus_out[v.ch]) begin
        stim_n++;
        if (rise_k < 0) rise_k = k;
      end
      if (res_valid) begin
        got   = 1'b1;
        g_ch  = int'(res_ch);
        g_st  = int'(res_status);
        g_cnt = int'(res_count);
      end
      if (v.mode == MEarly && k == 5) response_in[v.ch] = 1'b1;
      if (v.mode == MEarly && k == 9) response_in[v.ch] = 1'b0;
      if (v.mode == MResp && rise_k >= 0 && k == rise_k + 4 * v.n) response_in[v.ch] = 1'b1;
    end
    check({tag, " result seen"}, 32'(got), 32'd1);
    if (got) begin
      if (v.mode == MEarly) check({tag, " no stimulus"}, 32'(stim_n), 32'd0);
      else check_range({tag, " stim latency"}, rise_k, v.lat_lo, v.lat_hi);
      if (v.mode == MNone) check_range({tag, " stim duration"}, stim_n, 78, 81);
      check({tag, " res_ch"}, 32'(g_ch), 32'(v.ch));
      check({tag, " res_status"}, 32'(g_st), 32'(v.exp_st));
      check_range({tag, " res_count"}, g_cnt, v.cnt_lo, v.cnt_hi);
    end
    response_in[v.ch] = 1'b0;
    repeat (6) @(negedge clk);
    check({tag, " busy after"}, 32'(busy), 32'd0);
    check({tag, " fifo empty after"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    vec_t tail;
    vecs[0] = '{0, 5,  MResp, 12, 0, 12, 13, 19, 22};
    vecs[1] = '{1, 10, MEarly, 0, 1, 0,  0,  0,  0};
    vecs[2] = '{2, 0,  MNone,  0, 2, 20, 20, 2,  2};
    vecs[3] = '{3, 0,  MResp,  3, 0, 3,  4,  2,  2};
    vecs[4] = '{1, 1,  MResp,  0, 0, 0,  1,  3,  6};

    rst         = 1'b1;
    start       = 1'b0;
    ch_sel      = '0;
    delay_ticks = '0;
    abort       = 1'b0;
    response_in = '0;
    res_ready   = 1'b1;
    repeat (4) @(negedge clk);
    check("reset stimulus", 32'(stimulus_out), 32'd0);
    check("reset leds", 32'(egm_leds), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset res_fields", {res_ch, res_status, res_count}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_one(vecs[i], $sformatf("vec%0d", i));
    end

    // All four channels respond in the same cycle: results stream out in channel order.
    for (int c = 0; c < 4; c++) start_ch(c, 0);
    wait_stim(4'hF, "all stim high");
    check("all leds high", 32'(egm_leds), 32'hF);
    repeat (8) @(negedge clk);
    response_in = 4'hF;
    wait_valid("burst first valid");
    check("burst ch0", 32'(res_ch), 32'd0);
    check("burst ch0 status", 32'(res_status), 32'd0);
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("burst valid %0d", c), 32'(res_valid), 32'd1);
      check($sformatf("burst ch%0d", c), 32'(res_ch), 32'(c));
    end
    response_in = '0;
    repeat (4) @(negedge clk);
    check("burst drained", 32'(res_valid), 32'd0);
    check("burst busy", 32'(busy), 32'd0);

    // Back-pressure: FIFO holds two, channels 2 and 3 wait in DONE.
    res_ready = 1'b0;
    for (int c = 0; c < 4; c++) start_ch(c, 0);
    wait_stim(4'hF, "bp stim high");
    repeat (8) @(negedge clk);
    response_in = 4'hF;
    repeat (20) @(negedge clk);
    check("bp busy", 32'(busy), 32'hC);
    check("bp stim low", 32'(stimulus_out), 32'd0);
    check("bp valid", 32'(res_valid), 32'd1);
    check("bp head ch0", 32'(res_ch), 32'd0);
    res_ready = 1'b1;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("bp drain valid %0d", c), 32'(res_valid), 32'd1);
      check($sformatf("bp drain ch%0d", c), 32'(res_ch), 32'(c));
    end
    @(negedge clk);
    check("bp drained", 32'(res_valid), 32'd0);
    response_in = '0;
    repeat (4) @(negedge clk);
    check("bp busy after", 32'(busy), 32'd0);

    // Abort mid-STIM with one entry queued.
    res_ready = 1'b0;
    start_ch(3, 0);
    wait_stim(4'h8, "ab ch3 stim");
    response_in[3] = 1'b1;
    wait_valid("ab ch3 queued");
    response_in[3] = 1'b0;
    start_ch(0, 0);
    start_ch(1, 0);
    wait_stim(4'h3, "ab stim high");
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab stim low", 32'(stimulus_out), 32'd0);
    check("ab leds low", 32'(egm_leds), 32'd0);
    check("ab busy", 32'(busy), 32'd0);
    check("ab entry kept", 32'(res_valid), 32'd1);
    check("ab entry ch", 32'(res_ch), 32'd3);
    check("ab entry status", 32'(res_status), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    check("ab fifo empty", 32'(res_valid), 32'd0);
    tail = '{0, 0, MResp, 2, 0, 2, 3, 2, 2};
    run_one(tail, "rearm");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
